// File: rtl/i2c_slave_regs.sv
// I2C target with a 2**ADDR_W x 8 register file, auto-incrementing pointer,
// host-side read port and write strobes for the controller core.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst_slave,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              stop_evt
);
  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic [3:0] {
    IDLE = 4'd0, ADDR, ADDR_ACK, IGNORE, PTR, PTR_ACK,
    WR, WR_ACK, RD, MACK, WAIT_STOP
  } state_t;

  state_t            state_q;
  logic [2:0]        scl_q, sda_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shreg_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              rw_q, ack_q;
  logic              sda_oe_q, busy_q, wr_strobe_q, stop_evt_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        regs_q [NUM_REGS];

  logic              scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]        byte_d;
  logic [ADDR_W-1:0] ptr_inc_d;

  // [1] is the synchronised level, [2] the one-cycle history for edges
  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_s & ~scl_q[2];
  assign scl_fall  = ~scl_s & scl_q[2];
  assign start_det = scl_s & sda_q[2] & ~sda_s;
  assign stop_det  = scl_s & ~sda_q[2] & sda_s;
  assign byte_d    = {shreg_q[6:0], sda_s};
  assign ptr_inc_d = ptr_q + 1'b1;

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign stop_evt  = stop_evt_q;
  assign host_data = regs_q[host_addr];

  always_ff @(posedge clk) begin
    if (rst_slave) begin
      state_q     <= IDLE;
      scl_q       <= '1;
      sda_q       <= '1;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      stop_evt_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      scl_q       <= {scl_q[1:0], scl_in};
      sda_q       <= {sda_q[1:0], sda_in};
      wr_strobe_q <= 1'b0;
      stop_evt_q  <= 1'b0;
      // Commit one cycle after the strobe so the host sees the old value during it
      if (wr_strobe_q) regs_q[wr_addr_q] <= wr_data_q;

      if (stop_det) begin
        state_q    <= IDLE;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        stop_evt_q <= 1'b1;
        ack_q      <= 1'b0;
      end else if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        ack_q     <= 1'b0;
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            shreg_q <= byte_d;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              ack_q     <= 1'b0;
              if (byte_d[7:1] == SLAVE_ADDR) begin
                rw_q    <= byte_d[0];
                state_q <= ADDR_ACK;
              end else begin
                state_q <= IGNORE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          // ack_q=0: first fall starts the ACK; ack_q=1: second fall ends it
          ADDR_ACK: if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_q <= 1'b1;
              ack_q    <= 1'b1;
            end else begin
              ack_q     <= 1'b0;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
              if (rw_q) begin
                shreg_q  <= regs_q[ptr_q];
                sda_oe_q <= ~regs_q[ptr_q][7];
                state_q  <= RD;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= PTR;
              end
            end
          end
          PTR, WR: if (scl_rise) begin
            shreg_q <= byte_d;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              ack_q     <= 1'b0;
              if (state_q == PTR) begin
                ptr_q   <= byte_d[ADDR_W-1:0];
                state_q <= PTR_ACK;
              end else begin
                state_q <= WR_ACK;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          PTR_ACK, WR_ACK: if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_q <= 1'b1;
              ack_q    <= 1'b1;
              if (state_q == WR_ACK) begin
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= ptr_q;
                wr_data_q   <= shreg_q;
                ptr_q       <= ptr_inc_d;
              end
            end else begin
              sda_oe_q <= 1'b0;
              ack_q    <= 1'b0;
              state_q  <= WR;
            end
          end
          RD: if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_q <= 1'b0;
              ack_q    <= 1'b0;
              state_q  <= MACK;
            end else begin
              shreg_q   <= {shreg_q[6:0], 1'b0};
              sda_oe_q  <= ~shreg_q[6];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          MACK: begin
            if (scl_rise && !ack_q) begin
              if (!sda_s) begin
                ptr_q   <= ptr_inc_d;
                shreg_q <= regs_q[ptr_inc_d];
                ack_q   <= 1'b1;
              end else begin
                busy_q  <= 1'b0;
                state_q <= WAIT_STOP;
              end
            end else if (scl_fall && ack_q) begin
              sda_oe_q  <= ~shreg_q[7];
              bit_cnt_q <= '0;
              ack_q     <= 1'b0;
              state_q   <= RD;
            end
          end
          default: sda_oe_q <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bus-master tasks on an open-drain SDA model.
module tb_i2c_slave_regs;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_slave = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [3:0] host_addr = '0;
  logic [7:0] host_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       stop_evt;

  int total = 0;
  int bad = 0;

  int         n_wr = 0;
  int         n_stop = 0;
  logic       oe_seen = 1'b0;
  logic       pend = 1'b0;
  logic [3:0] log_a  [16];
  logic [7:0] log_d  [16];
  logic [7:0] log_hn [16];
  logic [7:0] log_hx [16];

  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h42), .ADDR_W(4)) dut (
    .clk(clk), .rst_slave(rst_slave), .scl_in(scl), .sda_in(sda_in),
    .sda_oe(sda_oe), .host_addr(host_addr), .host_data(host_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .stop_evt(stop_evt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pend) begin
      log_hx[n_wr-1] = host_data;
      pend = 1'b0;
    end
    if (wr_strobe && n_wr < 16) begin
      log_a[n_wr]  = wr_addr;
      log_d[n_wr]  = wr_data;
      log_hn[n_wr] = host_data;
      n_wr = n_wr + 1;
      pend = 1'b1;
    end
    if (stop_evt) n_stop = n_stop + 1;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hold(Q);
    scl = 1'b1;   hold(Q);
    sda_m = 1'b0; hold(Q);
    scl = 1'b0;   hold(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hold(Q);
    scl = 1'b1;   hold(Q);
    sda_m = 1'b1; hold(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;  hold(Q);
    scl = 1'b1; hold(2*Q);
    scl = 1'b0; hold(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; hold(Q);
    scl = 1'b1;   hold(Q);
    b = sda_in;   hold(Q);
    scl = 1'b0;   hold(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  task automatic test_reset();
    rst_slave = 1'b1;
    hold(4);
    rst_slave = 1'b0;
    hold(2);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b want=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_wr_strobe got=%b want=0", wr_strobe); end
    total++; if (stop_evt !== 1'b0) begin bad++; $display("FAIL reset_stop_evt got=%b want=0", stop_evt); end
    total++; if (wr_addr !== 4'h0 || wr_data !== 8'h00) begin
      bad++; $display("FAIL reset_wr_bus got=%h/%h want=0/00", wr_addr, wr_data);
    end
    for (int i = 0; i < 16; i++) begin
      host_addr = i[3:0]; hold(1);
      total++; if (host_data !== 8'h00) begin bad++; $display("FAIL reset_reg%0d got=%h want=00", i, host_data); end
    end
  endtask

  task automatic test_write3();
    logic ak;
    logic [7:0] bytes [5];
    int s0;
    bytes = '{8'h84, 8'h05, 8'h11, 8'h22, 8'h33};
    s0 = n_stop; n_wr = 0;
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(bytes[i], ak);
      total++; if (ak !== 1'b1) begin bad++; $display("FAIL write3_ack%0d got=%b want=1", i, ak); end
      if (i == 0) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL write3_busy got=%b want=1", busy); end
      end
    end
    i2c_stop();
    hold(4);
    total++; if (n_wr !== 3) begin bad++; $display("FAIL write3_nstrobe got=%0d want=3", n_wr); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (log_a[i] !== 4'(5 + i) || log_d[i] !== bytes[i+2]) begin
        bad++; $display("FAIL write3_strobe%0d got=%h/%h want=%h/%h", i, log_a[i], log_d[i], 4'(5 + i), bytes[i+2]);
      end
      host_addr = 4'(5 + i); hold(1);
      total++; if (host_data !== bytes[i+2]) begin bad++; $display("FAIL write3_reg%0d got=%h want=%h", 5 + i, host_data, bytes[i+2]); end
    end
    total++; if (n_stop - s0 !== 1) begin bad++; $display("FAIL write3_stop_evt got=%0d want=1", n_stop - s0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write3_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_read_after_write();
    logic ak;
    logic [7:0] d;
    logic [7:0] exp [3];
    exp = '{8'h11, 8'h22, 8'h33};
    i2c_start();
    write_byte(8'h84, ak);
    write_byte(8'h05, ak);
    i2c_start();
    write_byte(8'h85, ak);
    total++; if (ak !== 1'b1) begin bad++; $display("FAIL read_addr_ack got=%b want=1", ak); end
    for (int i = 0; i < 3; i++) begin
      read_byte(d, i < 2);
      total++; if (d !== exp[i]) begin bad++; $display("FAIL read_byte%0d got=%h want=%h", i, d, exp[i]); end
    end
    hold(4);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL read_release got=%b want=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_nack got=%b want=0", busy); end
    total++; if (dut.ptr_q !== 4'd7) begin bad++; $display("FAIL read_ptr got=%0d want=7", dut.ptr_q); end
    i2c_stop();
    hold(4);
  endtask

  task automatic test_wrong_addr();
    logic ak;
    n_wr = 0; oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h90, ak);
    total++; if (ak !== 1'b0) begin bad++; $display("FAIL wrong_addr_ack got=%b want=0", ak); end
    write_byte(8'h05, ak);
    write_byte(8'h77, ak);
    i2c_stop();
    hold(4);
    total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL wrong_addr_oe got=%b want=0", oe_seen); end
    total++; if (n_wr !== 0) begin bad++; $display("FAIL wrong_addr_strobe got=%0d want=0", n_wr); end
    host_addr = 4'd5; hold(1);
    total++; if (host_data !== 8'h11) begin bad++; $display("FAIL wrong_addr_reg5 got=%h want=11", host_data); end
    total++; if (dut.state_q !== 4'd0) begin bad++; $display("FAIL wrong_addr_state got=%0d want=0", dut.state_q); end
  endtask

  task automatic test_ptr_wrap();
    logic ak;
    i2c_start();
    write_byte(8'h84, ak);
    write_byte(8'h0F, ak);
    write_byte(8'hAA, ak);
    write_byte(8'hBB, ak);
    i2c_stop();
    hold(4);
    host_addr = 4'd15; hold(1);
    total++; if (host_data !== 8'hAA) begin bad++; $display("FAIL wrap_reg15 got=%h want=aa", host_data); end
    host_addr = 4'd0; hold(1);
    total++; if (host_data !== 8'hBB) begin bad++; $display("FAIL wrap_reg0 got=%h want=bb", host_data); end
    i2c_start();
    write_byte(8'h84, ak);
    write_byte(8'hF5, ak);
    i2c_stop();
    hold(4);
    total++; if (dut.ptr_q !== 4'd5) begin bad++; $display("FAIL wrap_ptr_upper got=%0d want=5", dut.ptr_q); end
  endtask

  task automatic test_midbyte_stop();
    logic ak;
    n_wr = 0;
    i2c_start();
    write_byte(8'h84, ak);
    write_byte(8'h08, ak);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    i2c_stop();
    hold(4);
    total++; if (n_wr !== 0) begin bad++; $display("FAIL midstop_strobe got=%0d want=0", n_wr); end
    total++; if (dut.state_q !== 4'd0) begin bad++; $display("FAIL midstop_state got=%0d want=0", dut.state_q); end
    host_addr = 4'd8; hold(1);
    total++; if (host_data !== 8'h00) begin bad++; $display("FAIL midstop_reg8 got=%h want=00", host_data); end
  endtask

  task automatic test_reset_mid_ack();
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 2);
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rstack_oe_before got=%b want=1", sda_oe); end
    rst_slave = 1'b1;
    hold(1);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rstack_oe_after got=%b want=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstack_busy got=%b want=0", busy); end
    rst_slave = 1'b0;
    for (int i = 0; i < 16; i += 5) begin
      host_addr = i[3:0]; hold(1);
      total++; if (host_data !== 8'h00) begin bad++; $display("FAIL rstack_reg%0d got=%h want=00", i, host_data); end
    end
    i2c_stop();
    hold(4);
  endtask

  task automatic test_loopback();
    logic ak;
    int s0;
    logic [7:0] seq [4];
    seq = '{8'h84, 8'h02, 8'h5A, 8'hC3};
    s0 = n_stop; n_wr = 0;
    host_addr = 4'd2;
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(seq[i], ak);
      total++; if (ak !== 1'b1) begin bad++; $display("FAIL loop_ack%0d got=%b want=1", i, ak); end
    end
    i2c_stop();
    hold(4);
    total++; if (n_wr !== 2) begin bad++; $display("FAIL loop_nstrobe got=%0d want=2", n_wr); end
    total++; if (log_hn[0] !== 8'h00 || log_hx[0] !== 8'h5A) begin
      bad++; $display("FAIL loop_host_timing got=%h->%h want=00->5a", log_hn[0], log_hx[0]);
    end
    host_addr = 4'd2; hold(1);
    total++; if (host_data !== 8'h5A) begin bad++; $display("FAIL loop_reg2 got=%h want=5a", host_data); end
    host_addr = 4'd3; hold(1);
    total++; if (host_data !== 8'hC3) begin bad++; $display("FAIL loop_reg3 got=%h want=c3", host_data); end
    total++; if (n_stop - s0 !== 1) begin bad++; $display("FAIL loop_stop got=%0d want=1", n_stop - s0); end
  endtask

  initial begin
    test_reset();
    test_write3();
    test_read_after_write();
    test_wrong_addr();
    test_ptr_wrap();
    test_midbyte_stop();
    test_reset_mid_ack();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
